// File: rtl/sha1_result_collector.sv
// Collects WORDS_PER_DIGEST consecutive words from the SHA-1 result FIFO and
// presents them as one digest (first word in the MSBs) with a valid/ready
// handshake. A running count of accepted digests is kept.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | issuing FIFO reads and capturing words into digest slots
// OUTPUT  | full digest presented on digest_data, waiting for digest_ready
module sha1_result_collector #(
  parameter int RES_DATA_WIDTH   = 32,
  parameter int WORDS_PER_DIGEST = 5,
  parameter int DIGEST_WIDTH     = RES_DATA_WIDTH * WORDS_PER_DIGEST
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [RES_DATA_WIDTH-1:0] result_dout,
  input  logic                      result_data_empty,
  output logic                      result_data_fifo_ren,
  input  logic                      collect_clr,
  output logic [DIGEST_WIDTH-1:0]   digest_data,
  output logic                      digest_val,
  input  logic                      digest_ready,
  output logic [15:0]               digest_cnt
);

  localparam int CW = $clog2(WORDS_PER_DIGEST + 1);
  localparam logic [CW-1:0] WORDS    = CW'(WORDS_PER_DIGEST);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS_PER_DIGEST - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] rd_issued;
  logic [CW-1:0] wr_cnt;
  logic          rd_pending;
  logic          run_en;
  logic          capture_last;
  logic          handshake;

  // The read issued last cycle returns its word now; the last slot completes the digest.
  assign capture_last = rd_pending && (wr_cnt == LAST_IDX);
  assign handshake    = (state == OUTPUT) && digest_ready;
  assign digest_val   = (state == OUTPUT);

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and read-enable decode; clear overrides everything.
  always_comb begin
    state_next           = state;
    result_data_fifo_ren = 1'b0;
    if (collect_clr) begin
      state_next = COLLECT;
    end else begin
      case (state)
        COLLECT: begin
          // run_en holds off reads until the first edge after reset release.
          result_data_fifo_ren = run_en && !result_data_empty && (rd_issued < WORDS);
          if (capture_last) begin
            state_next = OUTPUT;
          end
        end
        OUTPUT: begin
          if (digest_ready) begin
            state_next = COLLECT;
          end
        end
        default: state_next = COLLECT;
      endcase
    end
  end

  // Read bookkeeping, word capture into slots and the accepted-digest counter.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      run_en      <= 1'b0;
      rd_pending  <= 1'b0;
      rd_issued   <= '0;
      wr_cnt      <= '0;
      digest_data <= '0;
      digest_cnt  <= '0;
    end else begin
      run_en     <= 1'b1;
      rd_pending <= result_data_fifo_ren;
      if (collect_clr) begin
        // Any word returning this cycle belongs to the aborted digest and is dropped.
        rd_issued <= '0;
        wr_cnt    <= '0;
      end else if (handshake) begin
        rd_issued  <= '0;
        wr_cnt     <= '0;
        digest_cnt <= digest_cnt + 16'd1;
      end else begin
        if (result_data_fifo_ren) begin
          rd_issued <= rd_issued + CW'(1);
        end
        if (rd_pending) begin
          for (int k = 0; k < WORDS_PER_DIGEST; k++) begin
            if (wr_cnt == CW'(k)) begin
              digest_data[DIGEST_WIDTH-1-k*RES_DATA_WIDTH -: RES_DATA_WIDTH] <= result_dout;
            end
          end
          wr_cnt <= wr_cnt + CW'(1);
        end
      end
    end
  end

endmodule
